// File: rtl/rvpipe_skid_width3_pkg.sv
// Shared pipeline definitions for the skid buffer: state encoding and occupancy width.
// The state codes double as the occupancy count, so occ is the state register itself.
package rvpipe_skid_width3_pkg;

   localparam int OCC_W = 2;

   localparam logic [OCC_W-1:0] ST_EMPTY = 2'd0;
   localparam logic [OCC_W-1:0] ST_BUSY  = 2'd1;
   localparam logic [OCC_W-1:0] ST_FULL  = 2'd2;

   function automatic logic state_has_head(input logic [OCC_W-1:0] st);
      return (st == ST_BUSY) || (st == ST_FULL);
   endfunction

endpackage

// File: rtl/rvpipe_skid_width3_rvdff.sv
// Enabled payload flop with asynchronous active-high clear.
// Used for both the head and the skid payload registers.
module rvdff_width3 #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   always_comb begin
      data_d = en ? din : data_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign dout = data_q;

endmodule

// File: rtl/rvpipe_skid_width3.sv
// Two-entry ready/valid skid buffer; in_ready is registered so upstream sees
// no combinational path from out_ready.
module rvpipe_skid_width3
   import rvpipe_skid_width3_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] dout,
   input  logic             out_ready,
   output logic [1:0]       occ
);

   logic [OCC_W-1:0] state_q;
   logic [OCC_W-1:0] state_d;
   logic             in_ready_q;
   logic             in_ready_d;
   logic             main_en;
   logic             skid_en;
   logic [WIDTH-1:0] main_din;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   logic             xfer_in;
   logic             xfer_out;

   assign out_valid = state_has_head(state_q);
   assign xfer_in   = in_valid & in_ready_q;
   assign xfer_out  = out_valid & out_ready;

   // Refill from skid when draining FULL; otherwise the head takes fresh input.
   assign main_din = (state_q == ST_FULL) ? skid_q : in_data;

   always_comb begin
      state_d = state_q;
      main_en = 1'b0;
      skid_en = 1'b0;
      if (flush) begin
         // Loads are suppressed so discarded input never reaches dout.
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (xfer_in) begin
                  main_en = 1'b1;
                  state_d = ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (xfer_in && xfer_out) begin
                  main_en = 1'b1;
               end else if (xfer_in) begin
                  skid_en = 1'b1;
                  state_d = ST_FULL;
               end else if (xfer_out) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (xfer_out) begin
                  main_en = 1'b1;
                  state_d = ST_BUSY;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
      in_ready_d = (state_d != ST_FULL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
      end
   end

   rvdff_width3 #(.WIDTH(WIDTH)) u_main (
      .clk  (clk),
      .rst  (rst),
      .en   (main_en),
      .din  (main_din),
      .dout (main_q)
   );

   rvdff_width3 #(.WIDTH(WIDTH)) u_skid (
      .clk  (clk),
      .rst  (rst),
      .en   (skid_en),
      .din  (in_data),
      .dout (skid_q)
   );

   assign dout     = main_q;
   assign in_ready = in_ready_q;
   assign occ      = state_q;

endmodule
